amo_lrsc_unit: RTL and testbench

- Parametrised RV32A/RV64A atomic execution unit for the MEM stage of the pipelined core.
- Executes all nine AMO read-modify-write ops plus LR/SC, using a single-reservation register and a simple memory read/write handshake.
- Holds the pipeline via req_ready until resp_valid.
- Exports the reservation so the data-cache/arbiter can lock the word against other harts.

---
 rtl/amo_lrsc_if.sv | 43 ++++
 rtl/amo_lrsc_unit.sv | 198 +++++++++++++++++++
 tb/tb_amo_lrsc_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/amo_lrsc_if.sv
// Request/response, memory and reservation signals of the atomic unit.
// slave = the atomic unit, master = pipeline plus memory side.
interface amo_lrsc_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  // Handshake: a request transfers on a clock edge where req_valid && req_ready.
  // The request fields only need to be stable in that cycle. resp_valid is a
  // single-cycle pulse with no back-pressure. Memory requests are held until
  // the cycle in which mem_resp is high.
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_funct5;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_operand;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_data;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp;
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;

  modport slave (
    input  req_valid, req_funct5, req_addr, req_operand,
    input  mem_rdata, mem_resp, snoop_valid, snoop_addr,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata, rsv_valid, rsv_addr
  );

  modport master (
    output req_valid, req_funct5, req_addr, req_operand,
    output mem_rdata, mem_resp, snoop_valid, snoop_addr,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata, rsv_valid, rsv_addr
  );
endinterface

// File: rtl/amo_lrsc_unit.sv
// RV32A/RV64A atomic unit: AMO read-modify-write, LR/SC with one reservation.
// Define AMO_RSV_TIMEOUT_EN to expire an unused reservation after RSV_TIMEOUT cycles.
module amo_lrsc_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int RSV_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  amo_lrsc_if.slave    bus,
  output logic [2:0]   dbg_state
);
  localparam int WORD_LSB = $clog2(XLEN / 8);

  localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010,
                         F_SC  = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000,
                         F_AND = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100,
                         F_MINU = 5'b11000, F_MAXU = 5'b11100;

  typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, CALC = 3'd2, WRITE = 3'd3, DONE = 3'd4} state_t;

  state_t state_q, state_d;
  logic [4:0]        f5_q;
  logic [ADDR_W-1:0] addr_q, rsv_addr_q;
  logic [XLEN-1:0]   op_q, ld_q, res_q, resp_q, resp_d, amo_result;
  logic              err_q, err_d, rsv_valid_q;
  logic accept, ld_en, calc_en, sc_wr, resp_en, lr_set, rsv_kill;
  logic is_amo, sc_match, snoop_hit_rsv, snoop_hit_new, timeout_hit;

  function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:WORD_LSB] == b[ADDR_W-1:WORD_LSB];
  endfunction

  always_comb begin
    case (bus.req_funct5)
      F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU: is_amo = 1'b1;
      default: is_amo = 1'b0;
    endcase
  end

  assign snoop_hit_rsv = bus.snoop_valid && rsv_valid_q && same_word(bus.snoop_addr, rsv_addr_q);
  assign snoop_hit_new = bus.snoop_valid && same_word(bus.snoop_addr, addr_q);
  // A snoop or expiry in the decision cycle must fail the SC, not just clear later.
  assign sc_match = rsv_valid_q && same_word(bus.req_addr, rsv_addr_q) && !snoop_hit_rsv && !timeout_hit;

  always_comb begin
    amo_result = ld_q;
    case (f5_q)
      F_ADD:   amo_result = ld_q + op_q;
      F_SWAP:  amo_result = op_q;
      F_XOR:   amo_result = ld_q ^ op_q;
      F_OR:    amo_result = ld_q | op_q;
      F_AND:   amo_result = ld_q & op_q;
      F_MIN:   amo_result = ($signed(op_q) < $signed(ld_q)) ? op_q : ld_q;
      F_MAX:   amo_result = ($signed(op_q) > $signed(ld_q)) ? op_q : ld_q;
      F_MINU:  amo_result = (op_q < ld_q) ? op_q : ld_q;
      F_MAXU:  amo_result = (op_q > ld_q) ? op_q : ld_q;
      default: amo_result = ld_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ld_en    = 1'b0;
    calc_en  = 1'b0;
    sc_wr    = 1'b0;
    resp_en  = 1'b0;
    resp_d   = '0;
    err_d    = 1'b0;
    lr_set   = 1'b0;
    rsv_kill = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (is_amo || bus.req_funct5 == F_LR) begin
            state_d = READ;
          end else if (bus.req_funct5 == F_SC) begin
            if (sc_match) begin
              state_d = WRITE;
              sc_wr   = 1'b1;
            end else begin
              state_d  = DONE;
              resp_en  = 1'b1;
              resp_d   = XLEN'(1);
              rsv_kill = 1'b1;
            end
          end else begin
            state_d = DONE;
            resp_en = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      READ: begin
        if (bus.mem_resp) begin
          ld_en = 1'b1;
          if (f5_q == F_LR) begin
            state_d = DONE;
            resp_en = 1'b1;
            resp_d  = bus.mem_rdata;
            lr_set  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        calc_en = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.mem_resp) begin
          state_d  = DONE;
          resp_en  = 1'b1;
          resp_d   = (f5_q == F_SC) ? '0 : ld_q;
          rsv_kill = (f5_q == F_SC) || (rsv_valid_q && same_word(addr_q, rsv_addr_q));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f5_q   <= '0;
      addr_q <= '0;
      op_q   <= '0;
      ld_q   <= '0;
      res_q  <= '0;
      resp_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        f5_q   <= bus.req_funct5;
        addr_q <= bus.req_addr;
        op_q   <= bus.req_operand;
      end
      if (ld_en)        ld_q  <= bus.mem_rdata;
      if (calc_en)      res_q <= amo_result;
      else if (sc_wr)   res_q <= bus.req_operand;
      if (resp_en) begin
        resp_q <= resp_d;
        err_q  <= err_d;
      end
    end
  end

  // A new LR always replaces the old reservation; a same-cycle snoop voids the new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else if (lr_set) begin
      rsv_valid_q <= !snoop_hit_new;
      rsv_addr_q  <= snoop_hit_new ? '0 : addr_q;
    end else if (rsv_kill || snoop_hit_rsv || timeout_hit) begin
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end
  end

`ifdef AMO_RSV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RSV_TIMEOUT) + 1;
  logic [CNT_W-1:0] rsv_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            rsv_cnt_q <= '0;
    else if (lr_set)      rsv_cnt_q <= '0;
    else if (rsv_valid_q) rsv_cnt_q <= rsv_cnt_q + 1'b1;
  end

  assign timeout_hit = rsv_valid_q && (rsv_cnt_q == CNT_W'(RSV_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  if (RSV_TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = (state_q == DONE) ? resp_q : '0;
  assign bus.resp_err   = (state_q == DONE) && err_q;
  assign bus.mem_read   = (state_q == READ);
  assign bus.mem_write  = (state_q == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = (state_q == WRITE) ? res_q : '0;
  assign bus.rsv_valid  = rsv_valid_q;
  assign bus.rsv_addr   = rsv_valid_q ? rsv_addr_q : '0;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_amo_lrsc_unit.sv
// Directed bench for amo_lrsc_unit: AMO arithmetic, LR/SC, snoops, illegal op, reset mid-op.
// Build with AMO_RSV_TIMEOUT_EN defined to exercise reservation expiry (RSV_TIMEOUT=8).
module tb_amo_lrsc_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  int tests = 0;
  int fails = 0;

  int          n_reads, n_writes, n_pulses;
  bit          both_seen, busy_ok, idle_ok, timed_out;
  logic [31:0] got_wdata, got_data;
  logic        got_err;

  amo_lrsc_if #(.XLEN(32), .ADDR_W(32)) bus ();

  amo_lrsc_unit #(.XLEN(32), .ADDR_W(32), .RSV_TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and act as memory with 'lat' cycles of latency.
  task automatic run_op(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] opnd,
                        input logic [31:0] mword, input int lat);
    int wait_cnt;
    bit done;
    n_reads = 0; n_writes = 0; n_pulses = 0; both_seen = 0; got_wdata = '0; got_data = '0;
    got_err = 1'b0; timed_out = 1; wait_cnt = 0; done = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct5 = f5; bus.req_addr = addr; bus.req_operand = opnd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    busy_ok = !bus.req_ready;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.mem_resp = 1'b0;
      if (bus.mem_read && bus.mem_write) both_seen = 1;
      if (bus.resp_valid) begin
        n_pulses++; got_data = bus.resp_data; got_err = bus.resp_err; done = 1; timed_out = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          bus.mem_resp = 1'b1; wait_cnt = 0;
          if (bus.mem_read) begin bus.mem_rdata = mword; n_reads++; end
          else begin got_wdata = bus.mem_wdata; n_writes++; end
        end
      end
    end
    @(negedge clk);
    if (bus.resp_valid) n_pulses++;
    idle_ok = bus.req_ready;
    chk("no_timeout", 64'(timed_out), 64'd0);
  endtask

  task automatic amo_case(input string tag, input logic [4:0] f5, input logic [31:0] mword,
                          input logic [31:0] opnd, input logic [31:0] exp_w, input int lat);
    run_op(f5, 32'h20, opnd, mword, lat);
    chk({tag, "_wdata"}, 64'(got_wdata), 64'(exp_w));
    chk({tag, "_rdata"}, 64'(got_data), 64'(mword));
    chk({tag, "_rw"}, 64'({n_reads[3:0], n_writes[3:0]}), 64'h11);
    chk({tag, "_pulse"}, 64'(n_pulses), 64'd1);
    chk({tag, "_err"}, 64'(got_err), 64'd0);
    chk({tag, "_excl"}, 64'(both_seen), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_funct5 = '0; bus.req_addr = '0; bus.req_operand = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0; bus.snoop_valid = 1'b0; bus.snoop_addr = '0;

    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_outs", 64'({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write, bus.rsv_valid}), 64'd0);
    chk("rst_rsv_addr", 64'(bus.rsv_addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // AMOADD wrap with 2-cycle memory latency
    run_op(5'b00000, 32'h10, 32'h1, 32'h7FFF_FFFF, 2);
    chk("add_busy", 64'(busy_ok), 64'd1);
    chk("add_wdata", 64'(got_wdata), 64'h8000_0000);
    chk("add_rdata", 64'(got_data), 64'h7FFF_FFFF);
    chk("add_pulse", 64'(n_pulses), 64'd1);
    chk("add_idle", 64'(idle_ok), 64'd1);

    amo_case("min",  5'b10000, 32'hFFFF_FFFE, 32'h5, 32'hFFFF_FFFE, 1);
    amo_case("minu", 5'b11000, 32'hFFFF_FFFE, 32'h5, 32'h5, 2);
    amo_case("max",  5'b10100, 32'hFFFF_FFFE, 32'h5, 32'h5, 1);
    amo_case("maxu", 5'b11100, 32'hFFFF_FFFE, 32'h5, 32'hFFFF_FFFE, 3);
    amo_case("swap", 5'b00001, 32'h0000_1234, 32'hCAFE, 32'hCAFE, 1);
    amo_case("xor",  5'b00100, 32'h0000_F0F0, 32'hFF00, 32'h0000_0FF0, 1);
    amo_case("or",   5'b01000, 32'h0000_F0F0, 32'hFF00, 32'h0000_FFF0, 1);
    amo_case("and",  5'b01100, 32'h0000_F0F0, 32'hFF00, 32'h0000_F000, 1);

    // LR then successful SC
    run_op(5'b00010, 32'h100, 32'h0, 32'hAB, 1);
    chk("lr_data", 64'(got_data), 64'hAB);
    chk("lr_rsv_valid", 64'(bus.rsv_valid), 64'd1);
    chk("lr_rsv_addr", 64'(bus.rsv_addr), 64'h100);
    run_op(5'b00011, 32'h100, 32'h55, 32'h0, 1);
    chk("sc_ok_wdata", 64'(got_wdata), 64'h55);
    chk("sc_ok_rw", 64'({n_reads[3:0], n_writes[3:0]}), 64'h01);
    chk("sc_ok_data", 64'(got_data), 64'd0);
    chk("sc_ok_rsv", 64'(bus.rsv_valid), 64'd0);

    // Snoop to the same word kills the reservation; SC fails without memory access
    run_op(5'b00010, 32'h100, 32'h0, 32'hAB, 1);
    @(negedge clk);
    bus.snoop_valid = 1'b1; bus.snoop_addr = 32'h102;
    @(negedge clk);
    bus.snoop_valid = 1'b0;
    chk("snoop_clear", 64'(bus.rsv_valid), 64'd0);
    run_op(5'b00011, 32'h100, 32'h55, 32'h0, 1);
    chk("sc_snoop_rw", 64'({n_reads[3:0], n_writes[3:0]}), 64'h00);
    chk("sc_snoop_data", 64'(got_data), 64'd1);
    run_op(5'b00011, 32'h200, 32'h55, 32'h0, 1);
    chk("sc_norsv_rw", 64'({n_reads[3:0], n_writes[3:0]}), 64'h00);
    chk("sc_norsv_data", 64'(got_data), 64'd1);

    // Illegal funct5
    run_op(5'b11111, 32'h40, 32'h9, 32'h0, 1);
    chk("ill_err", 64'(got_err), 64'd1);
    chk("ill_data", 64'(got_data), 64'd0);
    chk("ill_rw", 64'({n_reads[3:0], n_writes[3:0]}), 64'h00);
    chk("ill_pulse", 64'(n_pulses), 64'd1);

    // AMO to another word keeps the reservation; AMO to the reserved word clears it
    run_op(5'b00010, 32'h40, 32'h0, 32'h3, 1);
    run_op(5'b01000, 32'h80, 32'h1, 32'h2, 1);
    chk("amo_other_rsv", 64'(bus.rsv_valid), 64'd1);
    run_op(5'b00000, 32'h40, 32'h1, 32'h3, 1);
    chk("amo_same_rsv", 64'(bus.rsv_valid), 64'd0);

    // Reset asserted while the AMO write is pending
    run_op(5'b00010, 32'h300, 32'h0, 32'h1, 1);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct5 = 5'b00000; bus.req_addr = 32'h300; bus.req_operand = 32'h1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    timed_out = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.mem_resp = 1'b0;
      if (bus.mem_write) begin timed_out = 0; break; end
      if (bus.mem_read) begin bus.mem_resp = 1'b1; bus.mem_rdata = 32'h5; end
      @(negedge clk);
    end
    chk("reach_write", 64'(timed_out), 64'd0);
    reset = 1'b1;
    #1;
    chk("rstw_outs", 64'({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write, bus.rsv_valid}), 64'd0);
    chk("rstw_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
    chk("rstw_rsv_addr", 64'(bus.rsv_addr), 64'd0);
    chk("rstw_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_resp = 1'b1;
    n_writes = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (bus.mem_write) n_writes++;
    end
    chk("rstw_no_write", 64'(n_writes), 64'd0);
    chk("stray_resp_idle", 64'(dbg_state), 64'd0);

    // Reservation lifetime
    run_op(5'b00010, 32'h500, 32'h0, 32'h1, 1);
    repeat (10) @(negedge clk);
    run_op(5'b00011, 32'h500, 32'h77, 32'h0, 1);
`ifdef AMO_RSV_TIMEOUT_EN
    chk("sc_expired", 64'(got_data), 64'd1);
`else
    chk("sc_persist", 64'(got_data), 64'd0);
`endif
    run_op(5'b00010, 32'h500, 32'h0, 32'h1, 1);
    repeat (3) @(negedge clk);
    run_op(5'b00011, 32'h500, 32'h77, 32'h0, 1);
    chk("sc_early", 64'(got_data), 64'd0);
    chk("sc_early_wdata", 64'(got_wdata), 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
